map_scanner: RTL

MAP_SCANNER -- requirements
Module: map_scanner

---
 rtl/map_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/map_scanner.sv
// rtl/map_scanner.sv - 8x8 coverage bitmap scanner: set-cell count and bounding box
//
// Purpose: accepts a 64-bit coverage map on map_valid and walks it one cell
// per clock (x fastest, then y). When the walk finishes it publishes the
// number of set cells and their bounding box (1-based coordinates).
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   map_in     in  64   cell (x,y) = map_in[8*(y-1)+(x-1)]
//   map_valid  in   1   start request, map_in sampled on the same edge
//   busy       out  1   scan in progress
//   done       out  1   result valid, held until the next accepted start
//   count      out  7   number of set cells, 0..64
//   empty      out  1   no set cells (valid with done)
//   min_x/max_x/min_y/max_y out 4  bounding box, all 0 when empty

module map_scanner (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] map_in,
    input  logic        map_valid,
    output logic        busy,
    output logic        done,
    output logic [6:0]  count,
    output logic        empty,
    output logic [3:0]  min_x,
    output logic [3:0]  max_x,
    output logic [3:0]  min_y,
    output logic [3:0]  max_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] map_q, map_d;
    logic [5:0]  idx_q, idx_d;

    // running accumulators for the scan in progress
    logic [6:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  acc_min_x_q, acc_min_x_d;
    logic [3:0]  acc_max_x_q, acc_max_x_d;
    logic [3:0]  acc_min_y_q, acc_min_y_d;
    logic [3:0]  acc_max_y_q, acc_max_y_d;

    // published result, only updated on entry to DONE
    logic [6:0]  count_q, count_d;
    logic        empty_q, empty_d;
    logic [3:0]  min_x_q, min_x_d;
    logic [3:0]  max_x_q, max_x_d;
    logic [3:0]  min_y_q, min_y_d;
    logic [3:0]  max_y_q, max_y_d;

    logic [3:0]  cell_x;
    logic [3:0]  cell_y;

    assign cell_x = {1'b0, idx_q[2:0]} + 4'd1;
    assign cell_y = {1'b0, idx_q[5:3]} + 4'd1;

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        idx_d       = idx_q;
        acc_cnt_d   = acc_cnt_q;
        acc_min_x_d = acc_min_x_q;
        acc_max_x_d = acc_max_x_q;
        acc_min_y_d = acc_min_y_q;
        acc_max_y_d = acc_max_y_q;
        count_d     = count_q;
        empty_d     = empty_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        min_y_d     = min_y_q;
        max_y_d     = max_y_q;

        case (state_q)
            IDLE, DONE: begin
                if (map_valid) begin
                    state_d     = SCAN;
                    map_d       = map_in;
                    idx_d       = 6'd0;
                    acc_cnt_d   = 7'd0;
                    acc_min_x_d = 4'd0;
                    acc_max_x_d = 4'd0;
                    acc_min_y_d = 4'd0;
                    acc_max_y_d = 4'd0;
                end
            end
            SCAN: begin
                if (map_q[idx_q]) begin
                    acc_cnt_d = acc_cnt_q + 7'd1;
                    if (acc_cnt_q == 7'd0) begin
                        // first set cell seeds the box; cleared zeros are not coordinates
                        acc_min_x_d = cell_x;
                        acc_max_x_d = cell_x;
                        acc_min_y_d = cell_y;
                        acc_max_y_d = cell_y;
                    end else begin
                        if (cell_x < acc_min_x_q) acc_min_x_d = cell_x;
                        if (cell_x > acc_max_x_q) acc_max_x_d = cell_x;
                        if (cell_y < acc_min_y_q) acc_min_y_d = cell_y;
                        if (cell_y > acc_max_y_q) acc_max_y_d = cell_y;
                    end
                end
                if (idx_q == 6'd63) begin
                    // publish including the last cell processed on this edge
                    state_d = DONE;
                    count_d = acc_cnt_d;
                    empty_d = (acc_cnt_d == 7'd0);
                    min_x_d = acc_min_x_d;
                    max_x_d = acc_max_x_d;
                    min_y_d = acc_min_y_d;
                    max_y_d = acc_max_y_d;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            map_q       <= 64'd0;
            idx_q       <= 6'd0;
            acc_cnt_q   <= 7'd0;
            acc_min_x_q <= 4'd0;
            acc_max_x_q <= 4'd0;
            acc_min_y_q <= 4'd0;
            acc_max_y_q <= 4'd0;
            count_q     <= 7'd0;
            empty_q     <= 1'b0;
            min_x_q     <= 4'd0;
            max_x_q     <= 4'd0;
            min_y_q     <= 4'd0;
            max_y_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            idx_q       <= idx_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_min_x_q <= acc_min_x_d;
            acc_max_x_q <= acc_max_x_d;
            acc_min_y_q <= acc_min_y_d;
            acc_max_y_q <= acc_max_y_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            min_y_q     <= min_y_d;
            max_y_q     <= max_y_d;
        end
    end

    assign busy  = (state_q == SCAN);
    assign done  = (state_q == DONE);
    assign count = count_q;
    assign empty = empty_q;
    assign min_x = min_x_q;
    assign max_x = max_x_q;
    assign min_y = min_y_q;
    assign max_y = max_y_q;

endmodule
